avalon_mm_csr_bank: RTL and testbench
=====================================

# avalon_mm_csr_bank

Parametrised Avalon-MM slave register bank: NUM_REGS read/write control registers plus NUM_REGS read-only status registers behind one Avalon-MM slave port. Reads are pipelined with a configurable fixed latency, and per-register write strobes are generated for downstream logic. It sits between the Avalon-MM interconnect and datapath blocks, replacing hand-written per-block register decoders.

## Interface
- DWIDTH, 32, data width; multiple of 8.
- NUM_REGS, 4, number of control registers and of status registers; ≥ 1.
- RD_LATENCY, 1, cycles from read accept to readdatavalid; 1..4.
- RST_VAL, 0, reset value of every control register (DWIDTH bits).
- AWIDTH, $clog2(NUM_REGS)+1, derived; MSB selects status (1) vs control (0).
- clk_i  in  1  clock.
- srst_i  in  1  synchronous reset, active-high.
- address_i  in  AWIDTH  word address.
- write_i  in  1  write request.
- writedata_i  in  DWIDTH  write data.
- byteenable_i  in  DWIDTH/8  byte mask (present only with AMM_CSR_BYTEENABLE_EN).
- read_i  in  1  read request.
- waitrequest_o  out  1  slave stall.
- readdata_o  out  DWIDTH  read data.
- readdatavalid_o  out  1  readdata qualifier.
- ctrl_o  out  NUM_REGS*DWIDTH  control register contents, reg k at bits [k*DWIDTH +: DWIDTH].
- wr_stb_o  out  NUM_REGS  one-cycle pulse per control register written.
- stat_i  in  NUM_REGS*DWIDTH  status inputs, same packing.

## Operation
- Address map: index = address_i[AWIDTH-2:0]; MSB=0 → control reg, MSB=1 → status reg. Index ≥ NUM_REGS is out of range.
- Accept: request accepted on a cycle with (write_i or read_i) and waitrequest_o=0.
- Write to control reg k: register updates at the accepting edge; wr_stb_o[k]=1 the following cycle for exactly one cycle.
- Write to status space or out-of-range index: ignored, no strobe, still accepted.
- Read: control reg value (including a write accepted the previous cycle) or stat_i sampled at the accepting cycle; out-of-range returns 0. Every accepted read yields exactly one readdatavalid_o.
- read_i and write_i both high: write performed, read dropped (no readdatavalid_o).
- waitrequest_o: 1 during reset and in the first cycle after srst_i deasserts; 0 otherwise. Block never back-pressures in normal operation.
- Read pipeline: RD_LATENCY-stage shift register of {valid, data}; reads accepted back-to-back on consecutive cycles return in order on consecutive cycles.
- Reset mid-operation: all in-flight reads discarded; no readdatavalid_o after reset.

## Timing
- Reset values: waitrequest_o=1, readdata_o=0, readdatavalid_o=0, wr_stb_o=0, ctrl_o = RST_VAL in every slot, pipeline valids 0.
- Read accepted at edge N → readdatavalid_o=1 with data in cycle N+RD_LATENCY; readdata_o returns to 0 when readdatavalid_o=0.
- Write accepted at edge N → ctrl_o and wr_stb_o change after edge N (visible cycle N+1).
- Throughput: one transaction per cycle sustained.

## Configuration
- AMM_CSR_BYTEENABLE_EN defined: byteenable_i port exists; write updates only bytes whose enable bit is 1; wr_stb_o fires if any bit of byteenable_i is 1; all-zero mask → no update, no strobe.
- Undefined: no byteenable_i port; every write updates the full word.

## Test plan
- Reset: hold srst_i 3 cycles, release → waitrequest_o=1 one more cycle then 0; ctrl_o all RST_VAL; no readdatavalid_o.
- Write 0xDEADBEEF to addr 1 then read addr 1 next cycle (RD_LATENCY=2) → wr_stb_o=4'b0010 one cycle; readdata_o=0xDEADBEEF with readdatavalid_o exactly 2 cycles after read accept.
- Back-to-back reads addr 0,1,2,3 with regs 0x10..0x13 → four consecutive readdatavalid_o cycles returning 0x10,0x11,0x12,0x13 in order.
- Status read: stat_i reg 2 = 0xA5A5A5A5, read addr 0b110 → 0xA5A5A5A5; write addr 0b110 → no strobe, no ctrl_o change; out-of-range with NUM_REGS=3 read index 3 → 0.
- Simultaneous read+write addr 0 value 0x55 → reg 0 = 0x55, no readdatavalid_o; srst_i asserted with 2 reads in flight → no readdatavalid_o afterwards.
- With AMM_CSR_BYTEENABLE_EN: reg 0 = 0x11223344, write 0xAABBCCDD byteenable 4'b0101 → 0x11BB33DD; byteenable 0 → unchanged, no strobe.

Source files
------------

// File: rtl/avalon_mm_csr_bank_if.sv
// Avalon-MM slave bus bundle for avalon_mm_csr_bank.
// Signal names carry the slave-side _i/_o direction suffix.
// Optional feature macro: AMM_CSR_BYTEENABLE_EN adds byteenable_i.
interface avalon_mm_csr_bank_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 3
);
  logic [AWIDTH-1:0]   address_i;
  logic                write_i;
  logic [DWIDTH-1:0]   writedata_i;
`ifdef AMM_CSR_BYTEENABLE_EN
  logic [DWIDTH/8-1:0] byteenable_i;
`endif
  logic                read_i;
  logic                waitrequest_o;
  logic [DWIDTH-1:0]   readdata_o;
  logic                readdatavalid_o;

  modport master (
    output address_i, write_i, writedata_i, read_i,
`ifdef AMM_CSR_BYTEENABLE_EN
    output byteenable_i,
`endif
    input  waitrequest_o, readdata_o, readdatavalid_o
  );

  modport slave (
    input  address_i, write_i, writedata_i, read_i,
`ifdef AMM_CSR_BYTEENABLE_EN
    input  byteenable_i,
`endif
    output waitrequest_o, readdata_o, readdatavalid_o
  );
endinterface

// File: rtl/avalon_mm_csr_bank.sv
// Avalon-MM slave register bank: NUM_REGS R/W control registers and NUM_REGS
// read-only status registers, fixed-latency pipelined reads, per-register
// write strobes. Address MSB selects status (1) or control (0).
// Optional feature macro: AMM_CSR_BYTEENABLE_EN (byte-masked writes).
module avalon_mm_csr_bank #(
  parameter int              DWIDTH     = 32,
  parameter int              NUM_REGS   = 4,
  parameter int              RD_LATENCY = 1,
  parameter logic [DWIDTH-1:0] RST_VAL  = '0,
  parameter int              AWIDTH     = $clog2(NUM_REGS) + 1
) (
  input  logic                       clk_i,
  input  logic                       srst_i,
  avalon_mm_csr_bank_if.slave        bus,
  output logic [NUM_REGS*DWIDTH-1:0] ctrl_o,
  output logic [NUM_REGS-1:0]        wr_stb_o,
  input  logic [NUM_REGS*DWIDTH-1:0] stat_i
);
  // Index width; with a single register the index collapses to a constant 0.
  localparam int IW = (AWIDTH > 1) ? AWIDTH - 1 : 1;

  logic                               wait_q;
  logic [NUM_REGS-1:0][DWIDTH-1:0]    ctrl_q, ctrl_d;
  logic [NUM_REGS-1:0][DWIDTH-1:0]    stat;
  logic [NUM_REGS-1:0]                wr_hit, wr_stb_q;
  logic [RD_LATENCY:1]                vld_pipe_q;
  logic [RD_LATENCY:1][DWIDTH-1:0]    dat_pipe_q;
  logic [IW-1:0]                      idx;
  logic                               is_stat, acc_wr, acc_rd, wr_any;
  logic [DWIDTH-1:0]                  wmask, rd_data;

  assign stat    = stat_i;
  assign idx     = (AWIDTH > 1) ? bus.address_i[IW-1:0] : '0;
  assign is_stat = bus.address_i[AWIDTH-1];

  // Stall covers reset plus one cycle after release, so a master never sees
  // an accept on the same edge the bank leaves reset.
  assign bus.waitrequest_o = srst_i | wait_q;
  assign acc_wr = bus.write_i & ~bus.waitrequest_o;
  // A read issued together with a write is dropped.
  assign acc_rd = bus.read_i & ~bus.write_i & ~bus.waitrequest_o;

`ifdef AMM_CSR_BYTEENABLE_EN
  // Expand byte enables to a bit mask; an all-zero mask is a no-op write.
  always_comb begin
    wmask = '0;
    for (int b = 0; b < DWIDTH/8; b++) wmask[b*8 +: 8] = {8{bus.byteenable_i[b]}};
  end
  assign wr_any = |bus.byteenable_i;
`else
  assign wmask  = '1;
  assign wr_any = 1'b1;
`endif

  // Decode which control register (if any) the accepted write targets.
  always_comb begin
    wr_hit = '0;
    for (int k = 0; k < NUM_REGS; k++)
      wr_hit[k] = acc_wr & ~is_stat & wr_any & (idx == IW'(k));
  end

  // Merge write data into the targeted control register.
  always_comb begin
    ctrl_d = ctrl_q;
    for (int k = 0; k < NUM_REGS; k++)
      if (wr_hit[k]) ctrl_d[k] = (ctrl_q[k] & ~wmask) | (bus.writedata_i & wmask);
  end

  // Read mux; indices with no matching register fall through to zero.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_REGS; k++)
      if (idx == IW'(k)) rd_data = is_stat ? stat[k] : ctrl_q[k];
  end

  // Control state, write strobes and post-reset stall flag.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wait_q   <= 1'b1;
      ctrl_q   <= {NUM_REGS{RST_VAL}};
      wr_stb_q <= '0;
    end else begin
      wait_q   <= 1'b0;
      ctrl_q   <= ctrl_d;
      wr_stb_q <= wr_hit;
    end
  end

  // Read return pipeline; data is zeroed when not valid so readdata_o idles at 0.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      vld_pipe_q <= '0;
      dat_pipe_q <= '0;
    end else begin
      vld_pipe_q[1] <= acc_rd;
      dat_pipe_q[1] <= acc_rd ? rd_data : '0;
      for (int s = 2; s <= RD_LATENCY; s++) begin
        vld_pipe_q[s] <= vld_pipe_q[s-1];
        dat_pipe_q[s] <= dat_pipe_q[s-1];
      end
    end
  end

  assign bus.readdatavalid_o = vld_pipe_q[RD_LATENCY];
  assign bus.readdata_o      = dat_pipe_q[RD_LATENCY];
  assign ctrl_o              = ctrl_q;
  assign wr_stb_o            = wr_stb_q;
endmodule

// File: tb/tb_avalon_mm_csr_bank.sv
// Directed bench for avalon_mm_csr_bank: dut0 (4 regs, latency 2) and
// dut1 (3 regs, latency 1, non-zero reset value) for out-of-range decode.
module tb_avalon_mm_csr_bank;
  logic          clk = 1'b0;
  logic          srst;
  logic [127:0]  ctrl0, stat0;
  logic [3:0]    stb0;
  logic [95:0]   ctrl1, stat1;
  logic [2:0]    stb1;
  int            n_chk = 0;
  int            n_err = 0;

  always #5 clk = ~clk;

  avalon_mm_csr_bank_if #(.DWIDTH(32), .AWIDTH(3)) bus0 ();
  avalon_mm_csr_bank_if #(.DWIDTH(32), .AWIDTH(3)) bus1 ();

  avalon_mm_csr_bank #(.DWIDTH(32), .NUM_REGS(4), .RD_LATENCY(2), .RST_VAL(32'h0)) dut0 (
    .clk_i(clk), .srst_i(srst), .bus(bus0), .ctrl_o(ctrl0), .wr_stb_o(stb0), .stat_i(stat0));

  avalon_mm_csr_bank #(.DWIDTH(32), .NUM_REGS(3), .RD_LATENCY(1), .RST_VAL(32'hC3)) dut1 (
    .clk_i(clk), .srst_i(srst), .bus(bus1), .ctrl_o(ctrl1), .wr_stb_o(stb1), .stat_i(stat1));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic idle0;
    bus0.write_i = 1'b0; bus0.read_i = 1'b0;
  endtask

  task automatic idle1;
    bus1.write_i = 1'b0; bus1.read_i = 1'b0;
  endtask

  task automatic wr0(input logic [2:0] a, input logic [31:0] d);
    bus0.address_i = a; bus0.writedata_i = d; bus0.write_i = 1'b1; bus0.read_i = 1'b0;
`ifdef AMM_CSR_BYTEENABLE_EN
    bus0.byteenable_i = 4'hF;
`endif
    tick; idle0;
  endtask

  task automatic rd0(input logic [2:0] a);
    bus0.address_i = a; bus0.read_i = 1'b1; bus0.write_i = 1'b0;
    tick; idle0;
  endtask

  task automatic wr1(input logic [2:0] a, input logic [31:0] d);
    bus1.address_i = a; bus1.writedata_i = d; bus1.write_i = 1'b1; bus1.read_i = 1'b0;
`ifdef AMM_CSR_BYTEENABLE_EN
    bus1.byteenable_i = 3'h0 | 4'hF;
`endif
    tick; idle1;
  endtask

  task automatic rd1(input logic [2:0] a);
    bus1.address_i = a; bus1.read_i = 1'b1; bus1.write_i = 1'b0;
    tick; idle1;
  endtask

  initial begin
    srst = 1'b1;
    bus0.address_i = '0; bus0.writedata_i = '0; idle0;
    bus1.address_i = '0; bus1.writedata_i = '0; idle1;
`ifdef AMM_CSR_BYTEENABLE_EN
    bus0.byteenable_i = 4'hF; bus1.byteenable_i = 4'hF;
`endif
    stat0 = '0;
    stat1 = '1;

    // Reset: three cycles held
    repeat (3) tick;
    chk("rst_wait",  128'(bus0.waitrequest_o), 128'd1);
    chk("rst_rdv",   128'(bus0.readdatavalid_o), 128'd0);
    chk("rst_rdata", 128'(bus0.readdata_o), 128'd0);
    chk("rst_stb",   128'(stb0), 128'd0);
    chk("rst_ctrl0", ctrl0, 128'd0);
    chk("rst_ctrl1", 128'(ctrl1), 128'(96'h000000C3_000000C3_000000C3));

    // Release; a read held during the stall cycle must not be accepted
    srst = 1'b0;
    bus0.read_i = 1'b1; bus0.address_i = 3'd0;
    chk("rel_wait1", 128'(bus0.waitrequest_o), 128'd1);
    tick; idle0;
    chk("rel_wait0", 128'(bus0.waitrequest_o), 128'd0);
    for (int i = 0; i < 3; i++) begin
      chk("stall_no_rdv", 128'(bus0.readdatavalid_o), 128'd0);
      tick;
    end

    // Write then read-after-write, latency 2
    wr0(3'd1, 32'hDEADBEEF);
    chk("wr1_ctrl", 128'(ctrl0[63:32]), 128'(32'hDEADBEEF));
    chk("wr1_stb",  128'(stb0), 128'(4'b0010));
    rd0(3'd1);
    chk("wr1_stb_off", 128'(stb0), 128'd0);
    chk("rd1_lat1_rdv", 128'(bus0.readdatavalid_o), 128'd0);
    tick;
    chk("rd1_rdv",   128'(bus0.readdatavalid_o), 128'd1);
    chk("rd1_rdata", 128'(bus0.readdata_o), 128'(32'hDEADBEEF));
    tick;
    chk("rd1_rdv_off",  128'(bus0.readdatavalid_o), 128'd0);
    chk("rd1_rdata_off", 128'(bus0.readdata_o), 128'd0);

    // Fill regs 0..3, then back-to-back reads
    wr0(3'd0, 32'h10);
    chk("stb_r0", 128'(stb0), 128'(4'b0001));
    wr0(3'd1, 32'h11);
    wr0(3'd2, 32'h12);
    wr0(3'd3, 32'h13);
    chk("stb_r3", 128'(stb0), 128'(4'b1000));
    chk("ctrl_fill", ctrl0, 128'h00000013_00000012_00000011_00000010);
    rd0(3'd0);
    rd0(3'd1);
    chk("b2b_v0", 128'(bus0.readdatavalid_o), 128'd1);
    chk("b2b_d0", 128'(bus0.readdata_o), 128'h10);
    rd0(3'd2);
    chk("b2b_d1", 128'({bus0.readdatavalid_o, bus0.readdata_o}), 128'({1'b1, 32'h11}));
    rd0(3'd3);
    chk("b2b_d2", 128'({bus0.readdatavalid_o, bus0.readdata_o}), 128'({1'b1, 32'h12}));
    tick;
    chk("b2b_d3", 128'({bus0.readdatavalid_o, bus0.readdata_o}), 128'({1'b1, 32'h13}));
    tick;
    chk("b2b_end", 128'(bus0.readdatavalid_o), 128'd0);

    // Status read, sampled at accept even if stat_i changes afterwards
    stat0 = 128'h00000000_A5A5A5A5_00000000_5A000001;
    rd0(3'b110);
    stat0 = '0;
    tick;
    chk("stat_rd", 128'({bus0.readdatavalid_o, bus0.readdata_o}), 128'({1'b1, 32'hA5A5A5A5}));
    tick;
    chk("stat_rd_off", 128'(bus0.readdatavalid_o), 128'd0);
    wr0(3'b110, 32'hFFFFFFFF);
    chk("stat_wr_stb",  128'(stb0), 128'd0);
    chk("stat_wr_ctrl", ctrl0, 128'h00000013_00000012_00000011_00000010);

    // Out-of-range indices on the 3-register bank
    rd1(3'b011);
    chk("oor_ctrl_rd", 128'({bus1.readdatavalid_o, bus1.readdata_o}), 128'({1'b1, 32'h0}));
    rd1(3'b111);
    chk("oor_stat_rd", 128'({bus1.readdatavalid_o, bus1.readdata_o}), 128'({1'b1, 32'h0}));
    rd1(3'b010);
    chk("b1_rstval_rd", 128'({bus1.readdatavalid_o, bus1.readdata_o}), 128'({1'b1, 32'hC3}));
    wr1(3'b011, 32'hFF);
    chk("oor_wr_stb",  128'(stb1), 128'd0);
    chk("oor_wr_ctrl", 128'(ctrl1), 128'(96'h000000C3_000000C3_000000C3));
    wr1(3'b001, 32'h77);
    chk("b1_wr_stb",  128'(stb1), 128'(3'b010));
    chk("b1_wr_ctrl", 128'(ctrl1), 128'(96'h000000C3_00000077_000000C3));

    // Simultaneous read + write: write wins, read dropped
    bus0.address_i = 3'd0; bus0.writedata_i = 32'h55;
    bus0.write_i = 1'b1; bus0.read_i = 1'b1;
    tick; idle0;
    chk("rw_ctrl", 128'(ctrl0[31:0]), 128'h55);
    chk("rw_stb",  128'(stb0), 128'(4'b0001));
    for (int i = 0; i < 3; i++) begin
      chk("rw_no_rdv", 128'(bus0.readdatavalid_o), 128'd0);
      tick;
    end

`ifdef AMM_CSR_BYTEENABLE_EN
    wr0(3'd0, 32'h11223344);
    bus0.address_i = 3'd0; bus0.writedata_i = 32'hAABBCCDD;
    bus0.byteenable_i = 4'b0101; bus0.write_i = 1'b1;
    tick; idle0;
    chk("be_merge", 128'(ctrl0[31:0]), 128'h11BB33DD);
    chk("be_stb",   128'(stb0), 128'(4'b0001));
    bus0.writedata_i = 32'hFFFFFFFF; bus0.byteenable_i = 4'b0000; bus0.write_i = 1'b1;
    tick; idle0;
    bus0.byteenable_i = 4'hF;
    chk("be0_ctrl", 128'(ctrl0[31:0]), 128'h11BB33DD);
    chk("be0_stb",  128'(stb0), 128'd0);
`endif

    // Reset with reads in flight: nothing comes out afterwards
    rd0(3'd0);
    rd0(3'd1);
    srst = 1'b1;
    tick;
    for (int i = 0; i < 4; i++) begin
      chk("rst_inflight_rdv", 128'(bus0.readdatavalid_o), 128'd0);
      tick;
    end
    chk("rst_mid_ctrl", ctrl0, 128'd0);
    srst = 1'b0;
    tick;
    for (int i = 0; i < 3; i++) begin
      chk("post_rst_rdv", 128'(bus0.readdatavalid_o), 128'd0);
      tick;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end
endmodule
